// File: rtl/mpb_rr_arb_pkg.sv
// Shared definitions for the MPB round-robin arbiter: FSM state encoding,
// grant-index width helper and stall counter width.
package mpb_rr_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle   = 2'd0;
    localparam arb_state_t StBusy   = 2'd1;
    localparam arb_state_t StLocked = 2'd2;

    // Width of the stall counter used when the timeout feature is compiled in.
    localparam int unsigned TimeoutCntW = 16;

    // Grant index width; never narrower than one bit.
    function automatic int unsigned gnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpb_rr_pick.sv
// Combinational round-robin picker. Returns the first asserted request at or
// after last+1 in circular order, using a double-width request vector so the
// wrap-around needs no separate priority path.
module mpb_rr_pick
    import mpb_rr_arb_pkg::*;
#(
    parameter int unsigned NUM_MAINS = 4,
    parameter int unsigned GW        = gnt_w(NUM_MAINS)
) (
    input  logic [NUM_MAINS-1:0] req,
    input  logic [GW-1:0]        last,
    output logic                 any,
    output logic [GW-1:0]        idx
);

    logic [2*NUM_MAINS-1:0] req_dbl;
    logic [2*NUM_MAINS-1:0] req_masked;

    // Lower copy keeps only mains after 'last'; upper copy supplies the wrap.
    always_comb begin
        req_dbl    = {req, req};
        req_masked = '0;
        for (int i = 0; i < 2 * NUM_MAINS; i++) begin
            req_masked[i] = req_dbl[i] && (i > int'(last));
        end
    end

    // Lowest set bit of the masked vector wins; fold it back to a main index.
    always_comb begin
        idx = '0;
        for (int i = 2 * NUM_MAINS - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                idx = GW'(i % NUM_MAINS);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mpb_rr_arb.sv
// N-main to 1-secondary round-robin arbiter for the Matrix Peripheral Bus.
// Optional stall timeout is compiled in with `define MPB_RR_ARB_TIMEOUT_EN,
// which also adds the timeout_err output.
module mpb_rr_arb
    import mpb_rr_arb_pkg::*;
#(
    parameter int unsigned NUM_MAINS      = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MAINS-1:0]             m_vld,
    input  logic [NUM_MAINS-1:0]             m_lock,
    input  logic [NUM_MAINS-1:0]             m_wr,
    input  logic [NUM_MAINS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_MAINS*DATA_WIDTH-1:0]  m_wdata,
    output logic [NUM_MAINS-1:0]             m_rdy,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             s_vld,
    output logic                             s_wr,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic                             s_rdy,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [gnt_w(NUM_MAINS)-1:0]      gnt_id,
    output logic                             busy
`ifdef MPB_RR_ARB_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    localparam int unsigned GW = gnt_w(NUM_MAINS);

    if (NUM_MAINS < 2 || NUM_MAINS > 16) begin : g_bad_num_mains
        $error("mpb_rr_arb: NUM_MAINS must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mpb_rr_arb: TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_t      state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;

    logic            pick_any;
    logic [GW-1:0]   pick_idx;

    logic            sel_vld;
    logic            sel_lock;
    logic            sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic            timeout_hit;

    mpb_rr_pick #(
        .NUM_MAINS (NUM_MAINS),
        .GW        (GW)
    ) u_pick (
        .req  (m_vld),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Request mux driven by the registered grant, never by the picker.
    always_comb begin
        sel_vld   = m_vld[gnt_q];
        sel_lock  = m_lock[gnt_q];
        sel_wr    = m_wr[gnt_q];
        sel_addr  = m_addr[gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = m_wdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef MPB_RR_ARB_TIMEOUT_EN
    logic [TimeoutCntW-1:0] stall_q, stall_d;

    assign timeout_hit = (state_q == StBusy) && (stall_q == TimeoutCntW'(TIMEOUT_CYCLES));
    assign timeout_err = timeout_hit;

    // Stall counter: held at zero outside BUSY, so it is clear on every BUSY entry.
    always_comb begin
        stall_d = stall_q;
        if (state_q != StBusy) begin
            stall_d = '0;
        end else if (sel_vld && !s_rdy && !timeout_hit) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, grant and last-grant update.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (timeout_hit) begin
                    // Forced completion ignores the lock request.
                    last_d  = gnt_q;
                    state_d = StIdle;
                end else if (sel_vld && s_rdy) begin
                    last_d  = gnt_q;
                    state_d = sel_lock ? StLocked : StIdle;
                end
            end
            StLocked: begin
                // A new request from the owner wins over a lock release.
                if (sel_vld) begin
                    state_d = StBusy;
                end else if (!sel_lock) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= GW'(NUM_MAINS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Secondary request and main response steering; everything idles at zero.
    always_comb begin
        s_vld   = 1'b0;
        s_wr    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        m_rdy   = '0;
        m_rdata = '0;
        if (state_q == StBusy) begin
            if (timeout_hit) begin
                m_rdy[gnt_q] = 1'b1;
                m_rdata      = '1;
            end else begin
                s_vld        = sel_vld;
                s_wr         = sel_wr;
                s_addr       = sel_addr;
                s_wdata      = sel_wdata;
                m_rdy[gnt_q] = s_rdy;
                if (s_rdy) begin
                    m_rdata = s_rdata;
                end
            end
        end
    end

    assign gnt_id = gnt_q;
    assign busy   = (state_q != StIdle);

endmodule
